// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Holds the 4-bit state encodings, opcode constants, aluop / PCSrc / aluSrcB codes,
// the bundled control-output record and small helper functions used by the
// controller and its output decoder.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXECUTE   = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_ADDI_EX   = 4'd10,
        ST_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_BREG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // All datapath control inputs driven by the controller.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       r_wbar;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_src;
        logic [1:0] aluop;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
    } ctrl_t;

    // Inactive control word: no writes, memory left in read mode, all selects zero.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c               = '0;
        c.r_wbar        = 1'b1;
        c.pc_src        = PCSRC_ALU;
        c.aluop         = ALUOP_ADD;
        c.alu_src_b     = SRCB_BREG;
        return c;
    endfunction

    // True for the opcodes the controller knows how to execute.
    function automatic logic op_supported(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: ok = 1'b1;
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Moore output decoder for the multicycle controller.
// Ports:
//   state - current controller state
//   ctrl  - full control word for the datapath, a pure function of state
import mips_ctrl_pkg::*;

module ctrl_out_decode (
    input  state_t state,
    output ctrl_t  ctrl
);

    // Map each state to its control word; unlisted fields keep the idle value.
    always_comb begin
        ctrl = ctrl_idle();
        case (state)
            ST_FETCH: begin
                ctrl.i_or_d    = 1'b0;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.aluop     = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.pc_write  = 1'b1;
            end
            ST_DECODE: begin
                // Branch target is precomputed into aluOutReg here.
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.aluop     = ALUOP_ADD;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.aluop     = ALUOP_ADD;
            end
            ST_MEM_READ: begin
                ctrl.i_or_d = 1'b1;
                ctrl.r_wbar = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            ST_MEM_WRITE: begin
                ctrl.i_or_d = 1'b1;
                ctrl.r_wbar = 1'b0;
            end
            ST_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_BREG;
                ctrl.aluop     = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_write  = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_BREG;
                ctrl.aluop         = ALUOP_SUB;
                ctrl.pc_src        = PCSRC_ALUOUT;
                ctrl.pc_write_cond = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
            end
            ST_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.aluop     = ALUOP_ADD;
            end
            ST_ADDI_WB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_write  = 1'b1;
            end
            default: begin
                ctrl = ctrl_idle();
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS core.
// Ports:
//   clk, rst        - clock and asynchronous active-high reset
//   opCode          - opcode from the instruction register
//   PCWrite .. RegDst - datapath control (write enables, selects, aluop, memory strobe)
//   state           - current FSM state (debug)
//   illegal_op      - one-cycle flag in the FETCH following an unsupported opcode
//   instr_count     - instructions fetched since reset (wraps)
//   cycle_count     - clock cycles since reset (wraps)
import mips_ctrl_pkg::*;

module multicycle_controller #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opCode,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               r_wbar,
    output logic               memToReg,
    output logic               IRWrite,
    output logic [1:0]         PCSrc,
    output logic [1:0]         aluop,
    output logic               aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic               RegWrite,
    output logic               RegDst,
    output logic [3:0]         state,
    output logic               illegal_op,
    output logic [COUNT_W-1:0] instr_count,
    output logic [COUNT_W-1:0] cycle_count
);

    state_t               state_r;
    state_t               next_state_s;
    logic                 illegal_op_r;
    logic [COUNT_W-1:0]   instr_count_r;
    logic [COUNT_W-1:0]   cycle_count_r;
    ctrl_t                dec_ctrl_s;
    ctrl_t                ctrl_s;

    ctrl_out_decode u_decode (
        .state (state_r),
        .ctrl  (dec_ctrl_s)
    );

    // Next-state selection; opCode is only consulted in DECODE and MEM_ADDR.
    always_comb begin
        next_state_s = ST_FETCH;
        case (state_r)
            ST_FETCH: next_state_s = ST_DECODE;
            ST_DECODE: begin
                case (opCode)
                    OP_RTYPE:     next_state_s = ST_EXECUTE;
                    OP_LW, OP_SW: next_state_s = ST_MEM_ADDR;
                    OP_BEQ:       next_state_s = ST_BRANCH;
                    OP_J:         next_state_s = ST_JUMP;
                    OP_ADDI:      next_state_s = ST_ADDI_EX;
                    default:      next_state_s = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR: begin
                if (opCode == OP_LW) begin
                    next_state_s = ST_MEM_READ;
                end else begin
                    next_state_s = ST_MEM_WRITE;
                end
            end
            ST_MEM_READ: next_state_s = ST_MEM_WB;
            ST_EXECUTE:  next_state_s = ST_R_WB;
            ST_ADDI_EX:  next_state_s = ST_ADDI_WB;
            default:     next_state_s = ST_FETCH;
        endcase
    end

    // State register, illegal-opcode flag and free-running counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_FETCH;
            illegal_op_r  <= 1'b0;
            instr_count_r <= '0;
            cycle_count_r <= '0;
        end else begin
            state_r       <= next_state_s;
            illegal_op_r  <= (state_r == ST_DECODE) && !op_supported(opCode);
            cycle_count_r <= cycle_count_r + COUNT_W'(1);
            if (state_r == ST_FETCH) begin
                instr_count_r <= instr_count_r + COUNT_W'(1);
            end else begin
                instr_count_r <= instr_count_r;
            end
        end
    end

    // Reset overrides the decoded word so no write strobe escapes while rst is high,
    // even though the state register already sits in FETCH.
    always_comb begin
        if (rst) begin
            ctrl_s = ctrl_idle();
        end else begin
            ctrl_s = dec_ctrl_s;
        end
    end

    assign PCWrite     = ctrl_s.pc_write;
    assign PCWriteCond = ctrl_s.pc_write_cond;
    assign IorD        = ctrl_s.i_or_d;
    assign r_wbar      = ctrl_s.r_wbar;
    assign memToReg    = ctrl_s.mem_to_reg;
    assign IRWrite     = ctrl_s.ir_write;
    assign PCSrc       = ctrl_s.pc_src;
    assign aluop       = ctrl_s.aluop;
    assign aluSrcA     = ctrl_s.alu_src_a;
    assign aluSrcB     = ctrl_s.alu_src_b;
    assign RegWrite    = ctrl_s.reg_write;
    assign RegDst      = ctrl_s.reg_dst;
    assign state       = state_r;
    assign illegal_op  = illegal_op_r;
    assign instr_count = instr_count_r;
    assign cycle_count = cycle_count_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: reset, a table of one instruction
// per class, mid-instruction reset, then random opcodes against a reference model.
// A second instance with 4-bit counters exercises counter wrap-around.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opCode = 6'd0;

    logic        PCWrite, PCWriteCond, IorD, r_wbar, memToReg, IRWrite;
    logic [1:0]  PCSrc, aluop, aluSrcB;
    logic        aluSrcA, RegWrite, RegDst, illegal_op;
    logic [3:0]  state;
    logic [31:0] instr_count, cycle_count;

    logic        w_PCWrite, w_PCWriteCond, w_IorD, w_r_wbar, w_memToReg, w_IRWrite;
    logic [1:0]  w_PCSrc, w_aluop, w_aluSrcB;
    logic        w_aluSrcA, w_RegWrite, w_RegDst, w_illegal_op;
    logic [3:0]  w_state;
    logic [3:0]  w_instr_count, w_cycle_count;

    multicycle_controller #(.COUNT_W(32)) dut (
        .clk(clk), .rst(rst), .opCode(opCode),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .r_wbar(r_wbar),
        .memToReg(memToReg), .IRWrite(IRWrite), .PCSrc(PCSrc), .aluop(aluop),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .RegWrite(RegWrite), .RegDst(RegDst),
        .state(state), .illegal_op(illegal_op),
        .instr_count(instr_count), .cycle_count(cycle_count)
    );

    multicycle_controller #(.COUNT_W(4)) dut_w4 (
        .clk(clk), .rst(rst), .opCode(opCode),
        .PCWrite(w_PCWrite), .PCWriteCond(w_PCWriteCond), .IorD(w_IorD), .r_wbar(w_r_wbar),
        .memToReg(w_memToReg), .IRWrite(w_IRWrite), .PCSrc(w_PCSrc), .aluop(w_aluop),
        .aluSrcA(w_aluSrcA), .aluSrcB(w_aluSrcB), .RegWrite(w_RegWrite), .RegDst(w_RegDst),
        .state(w_state), .illegal_op(w_illegal_op),
        .instr_count(w_instr_count), .cycle_count(w_cycle_count)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   exp_instr = 0;
    int   exp_cycle = 0;
    logic exp_illegal = 1'b0;

    typedef logic [3:0] st_q_t[$];

    typedef struct {
        string       name;
        logic [5:0]  op;
        int          len;
        logic [19:0] seq;   // state k in bits [4k+3:4k]
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Control word packed as {PCWrite,PCWriteCond,IorD,r_wbar,memToReg,IRWrite,PCSrc,aluop,aluSrcA,aluSrcB,RegWrite,RegDst}.
    function automatic logic [14:0] spec_ctrl(input logic [3:0] st);
        logic pcw, pcwc, iord, rw, m2r, irw, asa, rgw, rdst;
        logic [1:0] pcs, aop, asb;
        pcw = 1'b0; pcwc = 1'b0; iord = 1'b0; rw = 1'b1; m2r = 1'b0; irw = 1'b0;
        asa = 1'b0; rgw = 1'b0; rdst = 1'b0; pcs = 2'b00; aop = 2'b00; asb = 2'b00;
        case (st)
            4'd0:  begin irw = 1'b1; asb = 2'b01; pcw = 1'b1; end
            4'd1:  asb = 2'b11;
            4'd2:  begin asa = 1'b1; asb = 2'b10; end
            4'd3:  iord = 1'b1;
            4'd4:  begin m2r = 1'b1; rgw = 1'b1; end
            4'd5:  begin iord = 1'b1; rw = 1'b0; end
            4'd6:  begin asa = 1'b1; aop = 2'b10; end
            4'd7:  begin rdst = 1'b1; rgw = 1'b1; end
            4'd8:  begin asa = 1'b1; aop = 2'b01; pcs = 2'b01; pcwc = 1'b1; end
            4'd9:  begin pcs = 2'b10; pcw = 1'b1; end
            4'd10: begin asa = 1'b1; asb = 2'b10; end
            4'd11: rgw = 1'b1;
            default: ;
        endcase
        return {pcw, pcwc, iord, rw, m2r, irw, pcs, aop, asa, asb, rgw, rdst};
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
               (op == 6'b000100) || (op == 6'b000010) || (op == 6'b001000);
    endfunction

    // States visited by one instruction, from its instruction class.
    function automatic st_q_t model_states(input logic [5:0] op);
        st_q_t q;
        q.push_back(4'd0);
        q.push_back(4'd1);
        case (op)
            6'b100011: begin q.push_back(4'd2); q.push_back(4'd3); q.push_back(4'd4); end
            6'b101011: begin q.push_back(4'd2); q.push_back(4'd5); end
            6'b000000: begin q.push_back(4'd6); q.push_back(4'd7); end
            6'b001000: begin q.push_back(4'd10); q.push_back(4'd11); end
            6'b000100: q.push_back(4'd8);
            6'b000010: q.push_back(4'd9);
            default: ;
        endcase
        return q;
    endfunction

    function automatic logic [14:0] dut_ctrl();
        return {PCWrite, PCWriteCond, IorD, r_wbar, memToReg, IRWrite, PCSrc, aluop,
                aluSrcA, aluSrcB, RegWrite, RegDst};
    endfunction

    function automatic logic [14:0] dut_w4_ctrl();
        return {w_PCWrite, w_PCWriteCond, w_IorD, w_r_wbar, w_memToReg, w_IRWrite, w_PCSrc,
                w_aluop, w_aluSrcA, w_aluSrcB, w_RegWrite, w_RegDst};
    endfunction

    task automatic check_all(input string tag, input logic [3:0] exp_st, input logic [14:0] exp_ctrl);
        chk({tag, ".state"},     {28'd0, state},       {28'd0, exp_st});
        chk({tag, ".ctrl"},      {17'd0, dut_ctrl()},  {17'd0, exp_ctrl});
        chk({tag, ".illegal"},   {31'd0, illegal_op},  {31'd0, exp_illegal});
        chk({tag, ".instr"},     instr_count,          exp_instr);
        chk({tag, ".cycle"},     cycle_count,          exp_cycle);
        chk({tag, ".w4_state"},  {28'd0, w_state},     {28'd0, exp_st});
        chk({tag, ".w4_ctrl"},   {17'd0, dut_w4_ctrl()}, {17'd0, exp_ctrl});
        chk({tag, ".w4_illeg"},  {31'd0, w_illegal_op}, {31'd0, exp_illegal});
        chk({tag, ".w4_instr"},  {28'd0, w_instr_count}, exp_instr & 32'hF);
        chk({tag, ".w4_cycle"},  {28'd0, w_cycle_count}, exp_cycle & 32'hF);
    endtask

    // Advance one clock and update the model for the state just left.
    task automatic advance(input logic [3:0] st, input logic [5:0] op);
        exp_illegal = (st == 4'd1) && !is_legal(op);
        exp_cycle++;
        if (st == 4'd0) exp_instr++;
        @(negedge clk);
        #1;
    endtask

    task automatic run_model_instr(input logic [5:0] op);
        st_q_t q;
        q = model_states(op);
        opCode = op;
        foreach (q[i]) begin
            check_all($sformatf("rnd_op%02h_s%0d", op, i), q[i], spec_ctrl(q[i]));
            advance(q[i], op);
        end
    endtask

    task automatic model_reset();
        exp_instr = 0;
        exp_cycle = 0;
        exp_illegal = 1'b0;
    endtask

    vec_t        vt[7];
    logic [3:0]  st_tmp;
    logic [31:0] c0;
    logic [5:0]  legal_ops[6];

    initial begin
        vt[0] = '{name: "lw",    op: 6'b100011, len: 5, seq: 20'h43210};
        vt[1] = '{name: "sw",    op: 6'b101011, len: 4, seq: 20'h05210};
        vt[2] = '{name: "rtype", op: 6'b000000, len: 4, seq: 20'h07610};
        vt[3] = '{name: "beq",   op: 6'b000100, len: 3, seq: 20'h00810};
        vt[4] = '{name: "j",     op: 6'b000010, len: 3, seq: 20'h00910};
        vt[5] = '{name: "addi",  op: 6'b001000, len: 4, seq: 20'h0BA10};
        vt[6] = '{name: "ill",   op: 6'b111111, len: 2, seq: 20'h00010};
        legal_ops[0] = 6'b000000; legal_ops[1] = 6'b100011; legal_ops[2] = 6'b101011;
        legal_ops[3] = 6'b000100; legal_ops[4] = 6'b000010; legal_ops[5] = 6'b001000;

        // Reset held for three clocks: everything idle, counters cleared.
        repeat (3) @(negedge clk);
        #1;
        check_all("reset", 4'd0, 15'b000100000000000);

        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();

        // One instruction of each class, state sequence taken from the table.
        for (int i = 0; i < 7; i++) begin
            opCode = vt[i].op;
            c0 = cycle_count;
            for (int k = 0; k < vt[i].len; k++) begin
                st_tmp = vt[i].seq[4*k +: 4];
                check_all($sformatf("%s_s%0d", vt[i].name, k), st_tmp, spec_ctrl(st_tmp));
                advance(st_tmp, vt[i].op);
            end
            chk({vt[i].name, ".cycles"}, cycle_count - c0, vt[i].len);
        end
        // Illegal flag seen in the FETCH after the illegal opcode, then clears.
        check_all("after_ill", 4'd0, spec_ctrl(4'd0));
        chk("after_ill.flag_high", {31'd0, illegal_op}, 32'd1);
        advance(4'd0, 6'b000000);
        opCode = 6'b000000;
        check_all("after_ill_2", 4'd1, spec_ctrl(4'd1));
        chk("after_ill.flag_low", {31'd0, illegal_op}, 32'd0);
        advance(4'd1, 6'b000000);
        check_all("after_ill_3", 4'd6, spec_ctrl(4'd6));
        advance(4'd6, 6'b000000);
        check_all("after_ill_4", 4'd7, spec_ctrl(4'd7));
        advance(4'd7, 6'b000000);

        // Mid-instruction reset during MEM_READ of a lw.
        opCode = 6'b100011;
        for (int k = 0; k < 3; k++) begin
            st_tmp = 4'(k);
            check_all($sformatf("mid_lw_s%0d", k), st_tmp, spec_ctrl(st_tmp));
            advance(st_tmp, 6'b100011);
        end
        check_all("mid_lw_memread", 4'd3, spec_ctrl(4'd3));
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("mid_rst_now", 4'd0, 15'b000100000000000);
        @(posedge clk);
        #1;
        check_all("mid_rst_edge", 4'd0, 15'b000100000000000);
        chk("mid_rst.no_regwrite", {31'd0, RegWrite}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Random opcodes against the reference model; long enough to wrap 4-bit counters.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                run_model_instr(legal_ops[$urandom_range(0, 5)]);
            end else begin
                run_model_instr(6'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
